// File: rtl/wmst_axi_writer.sv
// wmst_axi_writer: AXI4 write master for the OFM flattening stage.
// Turns a (byte address, byte size) request plus a DATA_W-bit stream into
// one or more AXI4 INCR write bursts. Only one burst is in flight at a time.
// Pulses done after the final write response.
// Optional feature macro: WMST_4K_SPLIT_EN (clamp bursts at 4 KB boundaries).
module wmst_axi_writer #(
    parameter int DATA_W    = 512,
    parameter int ADDR_W    = 64,
    parameter int MAX_BEATS = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [ADDR_W-1:0]   xfer_size,
    output logic                done,
    output logic                busy,
    output logic                err,
    input  logic [DATA_W-1:0]   s_tdata,
    input  logic                s_valid,
    output logic                s_ready,
    output logic [ADDR_W-1:0]   awaddr,
    output logic [7:0]          awlen,
    output logic [2:0]          awsize,
    output logic [1:0]          awburst,
    output logic                awvalid,
    input  logic                awready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wlast,
    output logic                wvalid,
    input  logic                wready,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready
);

    localparam int         BPB     = DATA_W / 8;
    localparam int         LOG_BPB = $clog2(BPB);
    localparam int         BL_W    = ADDR_W - LOG_BPB;
    localparam logic [8:0] MAX_B   = 9'(MAX_BEATS);

    typedef enum logic [2:0] {IDLE, AW, W, B, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] cur_addr;
    logic [BL_W-1:0]   beats_left;
    logic [8:0]        beat_cnt;

    // Only the SLVERR/DECERR bit of the response matters here.
    logic unused_bresp;
    assign unused_bresp = bresp[0];

    // Whole beats in the request; sub-beat remainder bytes are dropped.
    logic [BL_W-1:0] req_beats;
    assign req_beats = xfer_size[ADDR_W-1:LOG_BPB];

    // Address of the burst after the one currently in flight (wraps naturally).
    logic [ADDR_W-1:0] next_addr;
    assign next_addr = cur_addr + (ADDR_W'({1'b0, awlen} + 9'd1) << LOG_BPB);

    function automatic logic [8:0] burst_len(input logic [BL_W-1:0] beats,
                                             input logic [8:0]      cap);
        if (beats > BL_W'(cap)) return cap;
        return beats[8:0];
    endfunction

    logic [8:0] req_cap;
    logic [8:0] nxt_cap;

`ifdef WMST_4K_SPLIT_EN
    // Beats left before the next 4 KB page, limited to MAX_BEATS.
    function automatic logic [8:0] page_cap(input logic [11:0] page_off);
        logic [12:0] room;
        room = (13'd4096 - {1'b0, page_off}) >> LOG_BPB;
        if (room < 13'(MAX_B)) return room[8:0];
        return MAX_B;
    endfunction

    assign req_cap = page_cap(addr[11:0]);
    assign nxt_cap = page_cap(next_addr[11:0]);
`else
    assign req_cap = MAX_B;
    assign nxt_cap = MAX_B;
`endif

    logic [8:0] req_burst;
    logic [8:0] nxt_burst;
    assign req_burst = burst_len(req_beats, req_cap);
    assign nxt_burst = burst_len(beats_left, nxt_cap);

    // Fixed AXI attributes: full-width beats, INCR bursts.
    assign awsize  = 3'(LOG_BPB);
    assign awburst = 2'b01;
    assign awaddr  = cur_addr;

    // W channel is a zero-latency pass-through, gated so nothing drains outside W.
    assign wvalid  = (state == W) && s_valid;
    assign s_ready = (state == W) && wready;
    assign wdata   = (state == W) ? s_tdata : '0;
    assign wstrb   = '1;
    assign wlast   = (state == W) && (beat_cnt == 9'd1);

    logic w_hs;
    assign w_hs = wvalid && wready;

    // Control FSM with registered AW, B and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: every flop here is a real control register, so all of them
            // get the async reset; non-blocking updates keep the FSM race-free.
            state      <= IDLE;
            cur_addr   <= '0;
            beats_left <= '0;
            beat_cnt   <= '0;
            awlen      <= '0;
            awvalid    <= 1'b0;
            bready     <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        cur_addr   <= addr;
                        beats_left <= req_beats;
                        err        <= |xfer_size[LOG_BPB-1:0];
                        busy       <= 1'b1;
                        if (req_beats == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state   <= AW;
                            awvalid <= 1'b1;
                            awlen   <= 8'(req_burst - 9'd1);
                        end
                    end
                end
                AW: begin
                    if (awready) begin
                        awvalid  <= 1'b0;
                        beat_cnt <= {1'b0, awlen} + 9'd1;
                        state    <= W;
                    end
                end
                W: begin
                    if (w_hs) begin
                        beat_cnt   <= beat_cnt - 9'd1;
                        beats_left <= beats_left - BL_W'(1);
                        if (beat_cnt == 9'd1) begin
                            state  <= B;
                            bready <= 1'b1;
                        end
                    end
                end
                B: begin
                    if (bvalid) begin
                        bready   <= 1'b0;
                        cur_addr <= next_addr;
                        if (bresp[1]) err <= 1'b1;
                        if (beats_left != '0) begin
                            state   <= AW;
                            awvalid <= 1'b1;
                            awlen   <= 8'(nxt_burst - 9'd1);
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wmst_axi_writer.sv
// Directed self-checking bench for wmst_axi_writer (default parameters).
`timescale 1ns/1ps
module tb_wmst_axi_writer;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req = 1'b0;
    logic [63:0]  addr = '0;
    logic [63:0]  xfer_size = '0;
    logic         done, busy, err;
    logic [511:0] s_tdata = '0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [63:0]  awaddr;
    logic [7:0]   awlen;
    logic [2:0]   awsize;
    logic [1:0]   awburst;
    logic         awvalid;
    logic         awready = 1'b1;
    logic [511:0] wdata;
    logic [63:0]  wstrb;
    logic         wlast, wvalid;
    logic         wready = 1'b1;
    logic [1:0]   bresp = 2'b00;
    logic         bvalid = 1'b0;
    logic         bready;

    always #5 clk = ~clk;

    wmst_axi_writer dut (
        .clk(clk), .rst_n(rst_n), .req(req), .addr(addr), .xfer_size(xfer_size),
        .done(done), .busy(busy), .err(err),
        .s_tdata(s_tdata), .s_valid(s_valid), .s_ready(s_ready),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Environment state: stream source, AXI slave and transaction logs.
    int          cyc = 0, src_idx = 0, src_len = 0, b_idx = 0, err_burst = -1;
    int          done_cnt = 0, b_hs_cyc = 0, done_cyc = 0;
    bit          stall = 1'b0;
    logic [31:0] tag = 32'h0;
    logic [63:0] aw_addr_q[$];
    logic [7:0]  aw_len_q[$];
    logic [511:0] w_q[$];
    int          last_q[$];

    function automatic logic [511:0] beat_data(input logic [31:0] t, input int i);
        return {16{t + 32'(i)}};
    endfunction

    // Observe at negedge, drive #1 after posedge.
    initial begin : env
        bit aw_hs, w_hs, b_hs, w_last;
        forever begin
            @(negedge clk);
            cyc++;
            aw_hs  = awvalid && awready;
            w_hs   = wvalid && wready;
            b_hs   = bvalid && bready;
            w_last = wlast;
            if (aw_hs) begin aw_addr_q.push_back(awaddr); aw_len_q.push_back(awlen); end
            if (w_hs) begin
                if (wlast) last_q.push_back(w_q.size());
                w_q.push_back(wdata);
            end
            if (b_hs) b_hs_cyc = cyc;
            if (done) begin done_cnt++; done_cyc = cyc; end
            @(posedge clk); #1;
            if (w_hs) src_idx++;
            if (b_hs) begin bvalid = 1'b0; bresp = 2'b00; b_idx++; end
            if (w_hs && w_last) begin
                bvalid = 1'b1;
                bresp  = (b_idx == err_burst) ? 2'b10 : 2'b00;
            end
            s_valid = (src_idx < src_len) && (!stall || $urandom_range(0, 3) != 0);
            s_tdata = beat_data(tag, src_idx);
            wready  = !stall || $urandom_range(0, 2) != 0;
            awready = !stall || $urandom_range(0, 1) != 0;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic sync();
        @(negedge clk); #1;
    endtask

    task automatic clear_env(input logic [31:0] t, input int n, input int eb, input bit st);
        aw_addr_q.delete(); aw_len_q.delete(); w_q.delete(); last_q.delete();
        src_idx = 0; src_len = n; b_idx = 0; err_burst = eb; stall = st; tag = t;
        done_cnt = 0; bvalid = 1'b0; bresp = 2'b00;
    endtask

    task automatic pulse_req(input logic [63:0] a, input logic [63:0] s);
        addr = a; xfer_size = s; req = 1'b1;
        sync();
        req = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit seen, output bit busy_at);
        seen = 1'b0; busy_at = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done) begin seen = 1'b1; busy_at = busy; break; end
            sync();
        end
    endtask

    task automatic test_reset();
        logic [7:0] flags;
        rst_n = 1'b0;
        repeat (2) sync();
        flags = {done, busy, err, awvalid, wvalid, wlast, bready, s_ready};
        n_checks++; if (flags !== 8'h00) $display("FAIL reset_flags: got %b want 00000000", flags); else n_pass++;
        n_checks++; if (awaddr !== 64'h0 || awlen !== 8'h0) $display("FAIL reset_aw: got addr=%h len=%0d want 0/0", awaddr, awlen); else n_pass++;
        n_checks++; if (awsize !== 3'd6 || awburst !== 2'b01) $display("FAIL reset_attr: got size=%0d burst=%b want 6/01", awsize, awburst); else n_pass++;
        rst_n = 1'b1;
        sync();
    endtask

    task automatic test_single();
        bit seen, busy_at;
        clear_env(32'h1000_0000, 2, -1, 1'b0);
        sync();
        pulse_req(64'h1000, 64'd128);
        n_checks++; if (busy !== 1'b1 || awvalid !== 1'b1) $display("FAIL single_t1: got busy=%b awvalid=%b want 1/1", busy, awvalid); else n_pass++;
        n_checks++; if (awaddr !== 64'h1000 || awlen !== 8'd1) $display("FAIL single_aw: got addr=%h len=%0d want 1000/1", awaddr, awlen); else n_pass++;
        wait_done(200, seen, busy_at);
        n_checks++; if (seen !== 1'b1) $display("FAIL single_done: done not seen, want within 200 cycles"); else n_pass++;
        n_checks++; if (busy_at !== 1'b1) $display("FAIL single_busy_at_done: got %b want 1", busy_at); else n_pass++;
        n_checks++; if (done_cyc - b_hs_cyc !== 1) $display("FAIL single_done_lat: got %0d want 1", done_cyc - b_hs_cyc); else n_pass++;
        n_checks++; if (w_q.size() !== 2 || last_q.size() !== 1 || last_q[0] !== 1) $display("FAIL single_w: got beats=%0d lasts=%0d want 2/1 at beat 2", w_q.size(), last_q.size()); else n_pass++;
        n_checks++; if (w_q[0] !== beat_data(tag, 0) || w_q[1] !== beat_data(tag, 1)) $display("FAIL single_data: got %h want %h", w_q[0][31:0], tag); else n_pass++;
        n_checks++; if (err !== 1'b0 || aw_len_q.size() !== 1) $display("FAIL single_err_aw: got err=%b aws=%0d want 0/1", err, aw_len_q.size()); else n_pass++;
        sync();
        n_checks++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL single_after: got done=%b busy=%b want 0/0", done, busy); else n_pass++;
    endtask

    task automatic test_multi();
        bit seen, busy_at;
        int bad;
        logic [63:0] exp_a[3];
        logic [7:0]  exp_l[3];
        int          exp_last[3];
        exp_a = '{64'h0, 64'h400, 64'h800};
        exp_l = '{8'd15, 8'd15, 8'd7};
        exp_last = '{15, 31, 39};
        clear_env(32'h2000_0000, 40, -1, 1'b0);
        sync();
        pulse_req(64'h0, 64'd2560);
        wait_done(400, seen, busy_at);
        n_checks++; if (seen !== 1'b1) $display("FAIL multi_done: done not seen, want within 400 cycles"); else n_pass++;
        bad = 0;
        for (int i = 0; i < 3; i++) if (aw_addr_q[i] !== exp_a[i] || aw_len_q[i] !== exp_l[i] || last_q[i] !== exp_last[i]) bad++;
        n_checks++; if (aw_len_q.size() !== 3 || last_q.size() !== 3 || bad !== 0) $display("FAIL multi_bursts: got aws=%0d lasts=%0d bad=%0d want 3/3/0", aw_len_q.size(), last_q.size(), bad); else n_pass++;
        bad = 0;
        for (int i = 0; i < w_q.size(); i++) if (w_q[i] !== beat_data(tag, i)) bad++;
        n_checks++; if (w_q.size() !== 40 || bad !== 0) $display("FAIL multi_data: got beats=%0d bad=%0d want 40/0", w_q.size(), bad); else n_pass++;
        repeat (5) sync();
        n_checks++; if (done_cnt !== 1) $display("FAIL multi_done_cnt: got %0d want 1", done_cnt); else n_pass++;
    endtask

    task automatic test_4k();
        bit seen, busy_at;
        clear_env(32'h3000_0000, 4, -1, 1'b0);
        sync();
        pulse_req(64'hFC0, 64'd256);
        wait_done(200, seen, busy_at);
        n_checks++; if (seen !== 1'b1) $display("FAIL 4k_done: done not seen, want within 200 cycles"); else n_pass++;
`ifdef WMST_4K_SPLIT_EN
        n_checks++; if (aw_len_q.size() !== 2 || aw_addr_q[0] !== 64'hFC0 || aw_len_q[0] !== 8'd0 || aw_addr_q[1] !== 64'h1000 || aw_len_q[1] !== 8'd2)
            $display("FAIL 4k_split: got n=%0d a0=%h l0=%0d a1=%h l1=%0d want 2 fc0/0 1000/2", aw_len_q.size(), aw_addr_q[0], aw_len_q[0], aw_addr_q[1], aw_len_q[1]); else n_pass++;
`else
        n_checks++; if (aw_len_q.size() !== 1 || aw_addr_q[0] !== 64'hFC0 || aw_len_q[0] !== 8'd3)
            $display("FAIL 4k_nosplit: got n=%0d a0=%h l0=%0d want 1 fc0/3", aw_len_q.size(), aw_addr_q[0], aw_len_q[0]); else n_pass++;
`endif
        n_checks++; if (w_q.size() !== 4 || w_q[3] !== beat_data(tag, 3)) $display("FAIL 4k_data: got beats=%0d want 4", w_q.size()); else n_pass++;
        sync();
    endtask

    task automatic test_zero_and_partial();
        bit seen, busy_at;
        clear_env(32'h4000_0000, 0, -1, 1'b0);
        sync();
        pulse_req(64'h5000, 64'd0);
        n_checks++; if (done !== 1'b1 || busy !== 1'b1 || awvalid !== 1'b0) $display("FAIL zero_t1: got done=%b busy=%b awvalid=%b want 1/1/0", done, busy, awvalid); else n_pass++;
        sync();
        n_checks++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL zero_t2: got done=%b busy=%b want 0/0", done, busy); else n_pass++;
        repeat (3) sync();
        n_checks++; if (aw_len_q.size() !== 0 || done_cnt !== 1) $display("FAIL zero_traffic: got aws=%0d dones=%0d want 0/1", aw_len_q.size(), done_cnt); else n_pass++;

        clear_env(32'h5000_0000, 2, -1, 1'b0);
        sync();
        pulse_req(64'h6000, 64'd100);
        n_checks++; if (err !== 1'b1) $display("FAIL partial_err_t1: got %b want 1", err); else n_pass++;
        wait_done(200, seen, busy_at);
        n_checks++; if (seen !== 1'b1 || err !== 1'b1) $display("FAIL partial_done: got seen=%b err=%b want 1/1", seen, err); else n_pass++;
        n_checks++; if (w_q.size() !== 1 || aw_len_q.size() !== 1 || aw_len_q[0] !== 8'd0) $display("FAIL partial_beats: got beats=%0d aws=%0d want 1/1 len 0", w_q.size(), aw_len_q.size()); else n_pass++;
        sync();
    endtask

    task automatic test_bresp_err();
        bit seen, busy_at;
        clear_env(32'h6000_0000, 20, 1, 1'b0);
        sync();
        pulse_req(64'h2000, 64'd1280);
        n_checks++; if (err !== 1'b0) $display("FAIL bresp_err_start: got %b want 0", err); else n_pass++;
        wait_done(300, seen, busy_at);
        n_checks++; if (seen !== 1'b1 || aw_len_q.size() !== 2 || aw_len_q[1] !== 8'd3) $display("FAIL bresp_bursts: got seen=%b aws=%0d want 1/2 second len 3", seen, aw_len_q.size()); else n_pass++;
        repeat (3) sync();
        n_checks++; if (err !== 1'b1) $display("FAIL bresp_err_sticky: got %b want 1", err); else n_pass++;
        clear_env(32'h7000_0000, 1, -1, 1'b0);
        sync();
        pulse_req(64'h7000, 64'd64);
        n_checks++; if (err !== 1'b0) $display("FAIL bresp_err_clear: got %b want 0", err); else n_pass++;
        wait_done(200, seen, busy_at);
        n_checks++; if (seen !== 1'b1 || err !== 1'b0) $display("FAIL bresp_clean_done: got seen=%b err=%b want 1/0", seen, err); else n_pass++;
        sync();
    endtask

    task automatic test_stalls();
        bit seen, busy_at, reached;
        int bad;
        clear_env(32'h8000_0000, 24, -1, 1'b1);
        sync();
        pulse_req(64'h3000, 64'd1536);
        reached = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (w_q.size() >= 3) begin reached = 1'b1; break; end
            sync();
        end
        n_checks++; if (reached !== 1'b1) $display("FAIL stall_progress: got %0d beats want >=3", w_q.size()); else n_pass++;
        pulse_req(64'h9000, 64'd64);
        wait_done(2000, seen, busy_at);
        n_checks++; if (seen !== 1'b1) $display("FAIL stall_done: done not seen, want within 2000 cycles"); else n_pass++;
        repeat (20) sync();
        n_checks++; if (done_cnt !== 1 || aw_len_q.size() !== 2) $display("FAIL stall_ignored_req: got dones=%0d aws=%0d want 1/2", done_cnt, aw_len_q.size()); else n_pass++;
        n_checks++; if (aw_addr_q[1] !== 64'h3400 || aw_len_q[0] !== 8'd15 || aw_len_q[1] !== 8'd7) $display("FAIL stall_aw: got a1=%h l0=%0d l1=%0d want 3400/15/7", aw_addr_q[1], aw_len_q[0], aw_len_q[1]); else n_pass++;
        bad = 0;
        for (int i = 0; i < w_q.size(); i++) if (w_q[i] !== beat_data(tag, i)) bad++;
        n_checks++; if (w_q.size() !== 24 || bad !== 0 || last_q.size() !== 2 || last_q[1] !== 23) $display("FAIL stall_order: got beats=%0d bad=%0d lasts=%0d want 24/0/2", w_q.size(), bad, last_q.size()); else n_pass++;
        clear_env(32'h0, 0, -1, 1'b0);
        sync();
    endtask

    task automatic test_reset_mid();
        bit seen, busy_at, reached;
        logic [7:0] flags;
        clear_env(32'h9000_0000, 8, -1, 1'b0);
        sync();
        pulse_req(64'h4000, 64'd512);
        reached = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (w_q.size() >= 2) begin reached = 1'b1; break; end
            sync();
        end
        n_checks++; if (reached !== 1'b1 || wvalid !== 1'b1) $display("FAIL rstmid_in_w: got beats=%0d wvalid=%b want >=2/1", w_q.size(), wvalid); else n_pass++;
        rst_n = 1'b0;
        #1;
        flags = {done, busy, err, awvalid, wvalid, wlast, bready, s_ready};
        n_checks++; if (flags !== 8'h00) $display("FAIL rstmid_flags: got %b want 00000000", flags); else n_pass++;
        n_checks++; if (awaddr !== 64'h0 || awlen !== 8'h0 || awsize !== 3'd6 || awburst !== 2'b01) $display("FAIL rstmid_aw: got addr=%h len=%0d size=%0d burst=%b", awaddr, awlen, awsize, awburst); else n_pass++;
        sync();
        rst_n = 1'b1;
        sync();
        clear_env(32'hA000_0000, 1, -1, 1'b0);
        sync();
        pulse_req(64'h8000, 64'd64);
        wait_done(200, seen, busy_at);
        n_checks++; if (seen !== 1'b1 || w_q.size() !== 1 || aw_addr_q[0] !== 64'h8000) $display("FAIL rstmid_recover: got seen=%b beats=%0d want 1/1 at 8000", seen, w_q.size()); else n_pass++;
        sync();
    endtask

    initial begin : main
        test_reset();
        test_single();
        test_multi();
        test_4k();
        test_zero_and_partial();
        test_bresp_err();
        test_stalls();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wmst_axi_writer.md
# wmst_axi_writer

AXI4 write master sitting directly downstream of the OFM flattening stage. It accepts a write request (`req`, byte address, byte size) plus a 512-bit output-feature-map stream. It converts them into one or more AXI4 INCR write bursts to external memory, then pulses `done` once the last write response has been received.

## Interface
Parameters:
- `DATA_W`, 512: stream and AXI data width in bits; bytes per beat `BPB = DATA_W/8` (64).
- `ADDR_W`, 64: address and size width.
- `MAX_BEATS`, 16: maximum beats per AXI burst (1..256).

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `req`  in  1  single-cycle request pulse.
- `addr`  in  ADDR_W  start byte address; sampled on accepted `req`.
- `xfer_size`  in  ADDR_W  byte count; sampled on accepted `req`.
- `done`  out  1  single-cycle completion pulse.
- `busy`  out  1  high from accepted `req` until `done`, inclusive.
- `err`  out  1  sticky error flag.
- `s_tdata`  in  DATA_W  stream data.
- `s_valid`  in  1  stream valid.
- `s_ready`  out  1  stream ready.
- `awaddr` (ADDR_W), `awlen` (8), `awsize` (3), `awburst` (2), `awvalid` (1)  out  AXI AW channel; `awready`  in  1.
- `wdata` (DATA_W), `wstrb` (DATA_W/8), `wlast` (1), `wvalid` (1)  out  AXI W channel; `wready`  in  1.
- `bresp`  in  2  AXI write response; `bvalid`  in  1; `bready`  out  1.

## Operation
- States: IDLE, AW, W, B, DONE.
- **IDLE**
  - `req` is accepted only in IDLE. It latches `addr` into `cur_addr`, sets `beats_left = xfer_size >> log2(BPB)` and clears `err`.
  - `req` outside IDLE is ignored; no queueing.
  - If `xfer_size[log2(BPB)-1:0] != 0`: set `err`; the remainder bytes are dropped.
  - If `beats_left == 0`: go to DONE with no AXI traffic. Otherwise go to AW.
- **AW**
  - `burst = min(beats_left, MAX_BEATS)`, plus the 4 KB clamp (see Configuration).
  - Drive `awaddr = cur_addr`, `awlen = burst-1`, `awsize = log2(BPB)`, `awburst = 2'b01`.
  - Hold `awvalid` until `awready`, then go to W with `beat_cnt = burst`.
- **W**
  - Pass-through: `wvalid = s_valid`, `s_ready = wready`, `wdata = s_tdata`, `wstrb` all ones.
  - `wlast = (beat_cnt == 1)`.
  - On each `wvalid & wready`: decrement `beat_cnt` and `beats_left`. On the last beat, go to B.
- **B**
  - `bready = 1`.
  - On `bvalid`: if `bresp[1]`, set `err`. Then `cur_addr += burst*BPB`.
  - If `beats_left != 0`, go to AW; otherwise go to DONE.
- **DONE**
  - `done = 1` for one cycle, then go to IDLE.
- Only one burst is outstanding; AW of burst n+1 is never issued before B of burst n.
- `s_ready = 0` outside W, so the stream never drains beyond the current burst.
- `err` stays set until the next accepted `req`.

## Timing
- Reset values:
  - State IDLE.
  - `done`, `busy`, `err`, `awvalid`, `wvalid`, `wlast`, `bready`, `s_ready` = 0.
  - `awaddr`, `awlen` = 0.
  - `awsize = log2(BPB)`, `awburst = 2'b01`.
- `req` sampled at edge T: `busy` and `awvalid` are high from T+1.
- Zero-size request: `done` at T+1 and `busy` at T+1 only.
- AW, B and DONE outputs are registered. W-channel valid, ready and data are combinational pass-throughs gated by state (zero added latency).
- `done` rises the cycle after the final B handshake.
- A new `req` may be accepted the cycle after `done`, i.e. back in IDLE.
- Simultaneous `bvalid` with a pending AW condition: the B handshake completes first; AW is issued the next cycle.
- Reset mid-burst: return immediately to IDLE with all outputs at reset values. The in-flight AXI transaction is abandoned, and the system must reset the slave as well.
- Arithmetic:
  - `cur_addr` wraps modulo 2^ADDR_W.
  - `beats_left` is ADDR_W-6 bits wide.
  - `awlen` is 8 bits; `MAX_BEATS` ≤ 256 is guaranteed by parameter.

## Configuration
- Macro: `WMST_4K_SPLIT_EN`.
- **Defined:** `burst` is additionally clamped to `(4096 - cur_addr[11:0]) / BPB`, so no burst crosses a 4 KB boundary. `addr` must be BPB-aligned.
- **Undefined:** no clamp; bursts may cross a 4 KB boundary. The caller guarantees legal addresses.

## Test plan
- `req`, addr=0x1000, size=128, `MAX_BEATS=16`, slave always ready -> one AW (awaddr=0x1000, awlen=1). Exactly 2 W beats, `wlast` on beat 2. `done` one cycle after `bvalid`; `err=0`.
- addr=0x0, size=64*40 -> three bursts with awlen=15,15,7 at addr 0x0, 0x400, 0x800. 40 W beats total; a single `done`.
- With `WMST_4K_SPLIT_EN`: addr=0xFC0, size=256 -> bursts awlen=0 at 0xFC0, then awlen=2 at 0x1000. Without the macro -> a single burst with awlen=3.
- size=0 -> `done` and `busy` high at T+1 only; no `awvalid`. size=100 -> 1 beat written and `err=1`.
- `bresp=2'b10` on the second of two bursts -> `err` stays 1 after `done`; the next `req` clears it.
- Random `s_valid`/`wready` stalls, plus a `req` pulsed during W -> data order is preserved and the second `req` is ignored (no extra `done`). `rst_n` low mid-W -> all outputs return to reset values within the same cycle.
